icache_assoc: RTL and testbench
===============================

ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 Parameter: NUM_SETS, default 16; number of sets, power of two, at least 2.
REQ-002 Parameter: LINE_WORDS, default 4; 32-bit words per line, power of two, at least 2.
REQ-003 Parameter: WAYS, default 2; associativity, power of two, at least 1.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 Reset_L  in  1  asynchronous, active-low reset.
REQ-006 InstrAddr  in  32  fetch byte address; bits [1:0] ignored.
REQ-007 Flush  in  1  invalidate all lines.
REQ-008 Instruction  out  32  word for InstrAddr when Hit=1, else 0.
REQ-009 Hit  out  1  InstrAddr present and valid this cycle.
REQ-010 MemRead  out  1  word read request to ROM controller.
REQ-011 MemReadAddr  out  32  word-aligned byte address of the requested word.
REQ-012 DataValid  in  1  ROM word on DataIn valid; completes the current request.
REQ-013 DataIn  in  32  ROM read data.

Function
REQ-014 Address split: [1:0] byte; next log2(LINE_WORDS) bits word offset; next log2(NUM_SETS) bits index; remaining upper bits tag. Defaults give offset [3:2], index [7:4], tag [31:8].
REQ-015 Lookup is combinational: Hit=1 iff state is IDLE and some way in the indexed set is valid with a matching tag; Instruction comes from that way.
REQ-016 FSM states are IDLE and FILL; reset state is IDLE.
REQ-017 IDLE and Hit=0 (not in reset): next cycle enter FILL.
REQ-018 On entering FILL, latch the line base (InstrAddr with offset and byte bits zeroed), the set index and the victim way; clear the word counter k.
REQ-019 Victim selection: the lowest-index invalid way in the set; if every way is valid, use the set's round-robin pointer.
REQ-020 In FILL: MemRead=1 and MemReadAddr = base + 4*k; both stay stable until DataValid=1 is sampled.
REQ-021 On a cycle with DataValid=1 in FILL: write DataIn to victim word k and increment k; the next request address is presented the following cycle.
REQ-022 When word LINE_WORDS-1 is accepted: write the tag, set valid, advance the set's pointer modulo WAYS if the pointer was used, and return to IDLE; Hit can go high the next cycle.
REQ-023 DataValid outside FILL is ignored.
REQ-024 InstrAddr changes during FILL do not affect the latched fill; the new address is looked up after return to IDLE.
REQ-025 Flush in IDLE clears every valid bit on that edge; Hit=0 in the following cycle.
REQ-026 Flush in FILL sets a pending flag; the fill completes all reads and is not marked valid; on completion all valids clear and the pending flag clears.
REQ-027 Outside FILL: MemRead=0 and MemReadAddr holds its last value.
REQ-028 Pointer width is max(1, log2(WAYS)); with WAYS=1 the victim is always way 0.

Reset
REQ-029 While Reset_L=0, asynchronously: state IDLE, k=0, all valid bits 0, all pointers 0, flush-pending 0, MemRead=0, MemReadAddr=0, hence Hit=0 and Instruction=0.
REQ-030 Reset mid-fill aborts the fill immediately and leaves no partial line valid; data and tag arrays need no reset.

Structure
REQ-031 Package icache_pkg holds the state enumeration and the helper functions that derive offset, index and tag widths from the parameters.
REQ-032 One sub-module, icache_way, holds the tag, valid and data storage for one way and its hit compare; it is instantiated WAYS times.

Verification
REQ-033 Cold miss: InstrAddr 0x40, DataValid one cycle after each request. Reads go to 0x40, 0x44, 0x48, 0x4C in order. Next cycle Hit=1 with the word returned for 0x40. A read of 0x4C then hits with MemRead staying 0.
REQ-034 Conflict (defaults): fill 0x040, then 0x140, then 0x240 (all set 4). 0x240 evicts way 0 (the 0x040 line). 0x140 still hits; 0x040 misses.
REQ-035 Stall: DataValid delayed 3 cycles per word. MemRead stays high with MemReadAddr stable for each wait, and exactly 4 words are written.
REQ-036 Flush pulse while word 2 is outstanding: all 4 reads complete. Afterwards 0x40 misses and a new fill starts.
REQ-037 Reset_L low during word 1: MemRead drops to 0 with no clock edge. After release, 0x40 misses.
REQ-038 InstrAddr moves to 0x80 during fill of 0x40. The 0x40 fill completes, then a fill of 0x80..0x8C starts with no extra read.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    // Word-offset field width inside a line.
    function automatic int off_width(input int line_words);
        return $clog2(line_words);
    endfunction

    // Set-index field width.
    function automatic int idx_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    // Tag is whatever remains above byte, offset and index bits of a 32-bit address.
    function automatic int tag_width(input int num_sets, input int line_words);
        return 30 - off_width(line_words) - idx_width(num_sets);
    endfunction

    // Round-robin pointer / way-number width; never narrower than one bit.
    function automatic int ptr_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid bits, tag array, line data and the combinational hit compare.
module icache_way
    import icache_pkg::*;
#(
    parameter int NUM_SETS   = 16,
    parameter int LINE_WORDS = 4,
    localparam int OFF_W     = off_width(LINE_WORDS),
    localparam int IDX_W     = idx_width(NUM_SETS),
    localparam int TAG_W     = tag_width(NUM_SETS, LINE_WORDS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    // lookup side
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [OFF_W-1:0] i_rd_off,
    input  logic [TAG_W-1:0] i_rd_tag,
    output logic             o_valid,
    output logic             o_hit,
    output logic [31:0]      o_data,
    // fill side
    input  logic             i_data_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [OFF_W-1:0] i_wr_off,
    input  logic [31:0]      i_wr_data,
    input  logic             i_tag_wr_en,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic             i_inval_all
);

    logic [NUM_SETS-1:0]    r_valid;
    logic [TAG_W-1:0]       r_tag  [NUM_SETS];
    logic [31:0]            r_data [NUM_SETS*LINE_WORDS];

    logic [IDX_W+OFF_W-1:0] w_rd_addr;
    logic [IDX_W+OFF_W-1:0] w_wr_addr;

    assign w_rd_addr = {i_rd_idx, i_rd_off};
    assign w_wr_addr = {i_wr_idx, i_wr_off};

    // Lookup must resolve in the same cycle, so the arrays are read combinationally.
    assign o_valid = r_valid[i_rd_idx];
    assign o_hit   = o_valid && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_data  = r_data[w_rd_addr];

    // Valid bits: flush wins over a line commit landing on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_inval_all) begin
            r_valid <= '0;
        end else if (i_tag_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag storage, written once when a fill commits.
    always_ff @(posedge i_clk) begin
        if (i_tag_wr_en) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    // Line data, written one word per accepted ROM beat.
    always_ff @(posedge i_clk) begin
        if (i_data_wr_en) begin
            r_data[w_wr_addr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with a word-at-a-time ROM line fill.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int NUM_SETS   = 16,
    parameter int LINE_WORDS = 4,
    parameter int WAYS       = 2
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [31:0] InstrAddr,
    input  logic        Flush,
    output logic [31:0] Instruction,
    output logic        Hit,
    output logic        MemRead,
    output logic [31:0] MemReadAddr,
    input  logic        DataValid,
    input  logic [31:0] DataIn
);

    localparam int OFF_W = off_width(LINE_WORDS);
    localparam int IDX_W = idx_width(NUM_SETS);
    localparam int TAG_W = tag_width(NUM_SETS, LINE_WORDS);
    localparam int PTR_W = ptr_width(WAYS);

    state_e           r_state;
    state_e           w_state_next;

    logic [OFF_W-1:0] r_k;
    logic [IDX_W-1:0] r_fill_idx;
    logic [TAG_W-1:0] r_fill_tag;
    logic [PTR_W-1:0] r_victim;
    logic             r_use_ptr;
    logic             r_flush_pend;
    logic [31:0]      r_mem_addr;
    logic [PTR_W-1:0] r_ptr [NUM_SETS];

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [WAYS-1:0]  w_way_hit;
    logic [WAYS-1:0]  w_way_valid;
    logic [31:0]      w_way_data [WAYS];
    logic             w_any_hit;
    logic [31:0]      w_hit_data;
    logic [PTR_W-1:0] w_victim_sel;
    logic             w_use_ptr_sel;
    logic             w_start;
    logic             w_accept;
    logic             w_last;
    logic             w_done;
    logic             w_flush_now;
    logic             w_commit;
    logic             w_inval_all;
    logic             w_unused_bits;

    // Byte-within-word bits never matter for a word fetch.
    assign w_unused_bits = &{1'b0, InstrAddr[1:0]};

    assign w_off = InstrAddr[OFF_W+1:2];
    assign w_idx = InstrAddr[OFF_W+IDX_W+1:OFF_W+2];
    assign w_tag = InstrAddr[31:OFF_W+IDX_W+2];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            icache_way #(
                .NUM_SETS   (NUM_SETS),
                .LINE_WORDS (LINE_WORDS)
            ) u_way (
                .i_clk        (CLK),
                .i_rst_n      (Reset_L),
                .i_rd_idx     (w_idx),
                .i_rd_off     (w_off),
                .i_rd_tag     (w_tag),
                .o_valid      (w_way_valid[gi]),
                .o_hit        (w_way_hit[gi]),
                .o_data       (w_way_data[gi]),
                .i_data_wr_en (w_accept && (r_victim == PTR_W'(gi))),
                .i_wr_idx     (r_fill_idx),
                .i_wr_off     (r_k),
                .i_wr_data    (DataIn),
                .i_tag_wr_en  (w_commit && (r_victim == PTR_W'(gi))),
                .i_wr_tag     (r_fill_tag),
                .i_inval_all  (w_inval_all)
            );
        end
    endgenerate

    // Merge per-way hits; at most one way can match a given tag.
    always_comb begin
        w_any_hit  = 1'b0;
        w_hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_way_hit[w]) begin
                w_any_hit  = 1'b1;
                w_hit_data = w_hit_data | w_way_data[w];
            end
        end
    end

    assign Hit         = (r_state == ST_IDLE) && w_any_hit;
    assign Instruction = Hit ? w_hit_data : 32'd0;

    // Victim choice: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        w_victim_sel  = r_ptr[w_idx];
        w_use_ptr_sel = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_way_valid[w]) begin
                w_victim_sel  = PTR_W'(w);
                w_use_ptr_sel = 1'b0;
            end
        end
    end

    assign w_start     = (r_state == ST_IDLE) && !w_any_hit;
    assign w_accept    = (r_state == ST_FILL) && DataValid;
    assign w_last      = (r_k == OFF_W'(LINE_WORDS - 1));
    assign w_done      = w_accept && w_last;
    // A flush arriving on the completing beat counts as pending too.
    assign w_flush_now = r_flush_pend || Flush;
    assign w_commit    = w_done && !w_flush_now;
    assign w_inval_all = ((r_state == ST_IDLE) && Flush) || (w_done && w_flush_now);

    // FSM state register.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and read-request strobe.
    always_comb begin
        w_state_next = r_state;
        MemRead      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_any_hit) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                MemRead = 1'b1;
                if (w_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign MemReadAddr = r_mem_addr;

    // Fill bookkeeping: latch line/victim on entry, step word counter per beat.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_k        <= '0;
            r_mem_addr <= '0;
            r_fill_idx <= '0;
            r_fill_tag <= '0;
            r_victim   <= '0;
            r_use_ptr  <= 1'b0;
        end else if (w_start) begin
            r_k        <= '0;
            r_mem_addr <= {InstrAddr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            r_fill_idx <= w_idx;
            r_fill_tag <= w_tag;
            r_victim   <= w_victim_sel;
            r_use_ptr  <= w_use_ptr_sel;
        end else if (w_accept) begin
            r_k <= r_k + OFF_W'(1);
            // The last address is held so it stays visible after the fill.
            if (!w_last) begin
                r_mem_addr <= r_mem_addr + 32'd4;
            end
        end
    end

    // Flush requested mid-fill is deferred until the line's reads finish.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_flush_pend <= 1'b0;
        end else if (w_done) begin
            r_flush_pend <= 1'b0;
        end else if ((r_state == ST_FILL) && Flush) begin
            r_flush_pend <= 1'b1;
        end
    end

    // Round-robin pointers advance only when a full set forced their use.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_ptr[s] <= '0;
            end
        end else if (w_done && r_use_ptr) begin
            r_ptr[r_fill_idx] <= (r_ptr[r_fill_idx] == PTR_W'(WAYS - 1))
                                 ? '0 : r_ptr[r_fill_idx] + PTR_W'(1);
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed scenarios then random fetches against a line-level model.
`timescale 1ns/1ps
module tb_icache_assoc;

    localparam int NUM_SETS   = 16;
    localparam int LINE_WORDS = 4;
    localparam int WAYS       = 2;
    localparam int LINE_BYTES = 4 * LINE_WORDS;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic [31:0] InstrAddr = 32'd0;
    logic        Flush = 1'b0;
    logic        DataValid = 1'b0;
    logic [31:0] DataIn = 32'd0;
    logic [31:0] Instruction;
    logic        Hit;
    logic        MemRead;
    logic [31:0] MemReadAddr;

    icache_assoc #(
        .NUM_SETS   (NUM_SETS),
        .LINE_WORDS (LINE_WORDS),
        .WAYS       (WAYS)
    ) dut (
        .CLK         (CLK),
        .Reset_L     (Reset_L),
        .InstrAddr   (InstrAddr),
        .Flush       (Flush),
        .Instruction (Instruction),
        .Hit         (Hit),
        .MemRead     (MemRead),
        .MemReadAddr (MemReadAddr),
        .DataValid   (DataValid),
        .DataIn      (DataIn)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: which line tag each way of each set holds, plus round-robin pointers.
    bit          m_valid [NUM_SETS][WAYS];
    int unsigned m_tag   [NUM_SETS][WAYS];
    int          m_ptr   [NUM_SETS];

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a / LINE_BYTES) % NUM_SETS);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a / (LINE_BYTES * NUM_SETS);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_fill(input logic [31:0] a, input bit flushed);
        int s = set_of(a);
        int v = -1;
        for (int w = 0; w < WAYS; w++)
            if (v < 0 && !m_valid[s][w]) v = w;
        if (v < 0) begin
            v = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end
        if (flushed) model_flush();
        else begin
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = tag_of(a);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset_L = 1'b0;
        #1;
        chk("rst_hit", {31'd0, Hit}, 32'd1 - 32'd1);
        chk("rst_instr", Instruction, 32'd0);
        chk("rst_memread", {31'd0, MemRead}, 32'd0);
        chk("rst_memaddr", MemReadAddr, 32'd0);
        model_reset();
        tick();
        tick();
        Reset_L = 1'b1;
    endtask

    // Present an address; on a miss serve the line fill with the given stall per word.
    task automatic fetch(input logic [31:0] a, input int dly, input int flush_word,
                         input int alt_word, input logic [31:0] alt_addr);
        logic [31:0] base;
        logic [31:0] word_addr;
        bit exp_hit;
        bit flushed;
        InstrAddr = a;
        #1;
        exp_hit = model_hit(a);
        chk("hit", {31'd0, Hit}, {31'd0, exp_hit});
        chk("instr", Instruction, exp_hit ? rom({a[31:2], 2'b00}) : 32'd0);
        chk("memread_idle", {31'd0, MemRead}, 32'd0);
        tick();
        if (exp_hit) return;
        base    = a - (a % LINE_BYTES);
        flushed = 1'b0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (w == alt_word) InstrAddr = alt_addr;
            word_addr = base + 32'(4 * w);
            chk("rd_req", {31'd0, MemRead}, 32'd1);
            chk("rd_addr", MemReadAddr, word_addr);
            if (w == flush_word) begin
                Flush = 1'b1;
                tick();
                Flush = 1'b0;
                flushed = 1'b1;
                chk("flush_req", {31'd0, MemRead}, 32'd1);
                chk("flush_addr", MemReadAddr, word_addr);
            end
            for (int d = 0; d < dly; d++) begin
                tick();
                chk("stall_req", {31'd0, MemRead}, 32'd1);
                chk("stall_addr", MemReadAddr, word_addr);
                chk("stall_hit", {31'd0, Hit}, 32'd0);
            end
            DataValid = 1'b1;
            DataIn    = rom(word_addr);
            tick();
            DataValid = 1'b0;
            DataIn    = $urandom;
        end
        model_fill(base, flushed);
        #1;
        exp_hit = model_hit(InstrAddr);
        $display("fill base=%h flushed=%0d next_addr=%h hit=%0d", base, flushed, InstrAddr, Hit);
        chk("done_hit", {31'd0, Hit}, {31'd0, exp_hit});
        chk("done_instr", Instruction, exp_hit ? rom({InstrAddr[31:2], 2'b00}) : 32'd0);
        chk("done_memread", {31'd0, MemRead}, 32'd0);
        chk("done_memaddr", MemReadAddr, base + 32'(4 * (LINE_WORDS - 1)));
    endtask

    // Flush while idle on a hitting address; caller must re-fetch immediately.
    task automatic flush_idle();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        model_flush();
        $display("flush idle at addr=%h", InstrAddr);
    endtask

    initial begin
        logic [31:0] a;
        int r;

        // Cold miss, in-order reads, then a hit on the last word of the line.
        do_reset();
        fetch(32'h40, 0, -1, -1, 32'd0);
        fetch(32'h4C, 0, -1, -1, 32'd0);

        // Conflict in set 4: third line evicts way 0.
        fetch(32'h140, 0, -1, -1, 32'd0);
        fetch(32'h240, 0, -1, -1, 32'd0);
        fetch(32'h144, 0, -1, -1, 32'd0);
        fetch(32'h048, 0, -1, -1, 32'd0);

        // Stalled ROM: three idle cycles before each beat.
        do_reset();
        fetch(32'h40, 3, -1, -1, 32'd0);

        // Flush while word 2 is outstanding: line completes but is dropped.
        do_reset();
        fetch(32'h40, 0, 2, -1, 32'd0);
        fetch(32'h40, 1, -1, -1, 32'd0);

        // Reset during word 1 drops MemRead without a clock edge.
        do_reset();
        InstrAddr = 32'h40;
        #1;
        chk("rf_hit", {31'd0, Hit}, 32'd0);
        tick();
        chk("rf_addr0", MemReadAddr, 32'h40);
        DataValid = 1'b1;
        DataIn    = rom(32'h40);
        tick();
        DataValid = 1'b0;
        chk("rf_addr1", MemReadAddr, 32'h44);
        chk("rf_req1", {31'd0, MemRead}, 32'd1);
        #2;
        Reset_L = 1'b0;
        #1;
        chk("rf_async_memread", {31'd0, MemRead}, 32'd0);
        chk("rf_async_memaddr", MemReadAddr, 32'd0);
        do_reset();
        fetch(32'h40, 0, -1, -1, 32'd0);

        // Address moves during a fill; the second line follows directly.
        do_reset();
        fetch(32'h40, 1, -1, 1, 32'h80);
        fetch(32'h80, 0, -1, -1, 32'd0);
        fetch(32'h44, 0, -1, -1, 32'd0);

        // Flush while idle.
        flush_idle();
        fetch(InstrAddr, 0, -1, -1, 32'd0);

        // Random fetch stream over a few tags per set.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                flush_idle();
                fetch(InstrAddr, 0, -1, -1, 32'd0);
            end else if (r == 1) begin
                DataValid = 1'b1;
                DataIn    = $urandom;
                tick();
                DataValid = 1'b0;
                $display("stray DataValid at addr=%h", InstrAddr);
                fetch(InstrAddr, 0, -1, -1, 32'd0);
            end else begin
                a = (32'($urandom_range(0, 3)) * LINE_BYTES * NUM_SETS)
                  + (32'($urandom_range(0, NUM_SETS - 1)) * LINE_BYTES)
                  + 32'($urandom_range(0, LINE_BYTES - 1));
                fetch(a, $urandom_range(0, 2), -1, -1, 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
